// File: rtl/i2c_slave.sv
// I2C slave endpoint: oversampled sclk/sda, START/STOP detection, 7-bit address match,
// byte receive into the core and byte transmit from it, with ACK/NACK on every byte.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h2D,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX        = 3'd3,
    RX_ACK    = 3'd4,
    TX        = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, sda_sync_q, sda_sync_d;
  logic       sclk_prev_q, sda_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_out_q, sda_out_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       byte_done_q, byte_done_d;

  logic sclk_s, sda_s, sclk_rise, sclk_fall, start_cond, stop_cond, addr_match;

  always_comb begin
    sclk_sync_d    = sclk_sync_q << 1;
    sclk_sync_d[0] = sclk;
    sda_sync_d     = sda_sync_q << 1;
    sda_sync_d[0]  = sda_in;
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign start_cond = sclk_s & sclk_prev_q & sda_prev_q & ~sda_s;
  assign stop_cond  = sclk_s & sclk_prev_q & ~sda_prev_q & sda_s;
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '1;
      sda_sync_q  <= '1;
      sclk_prev_q <= 1'b1;
      sda_prev_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      sda_out_q   <= 1'b1;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      sda_sync_q  <= sda_sync_d;
      sclk_prev_q <= sclk_s;
      sda_prev_q  <= sda_s;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      sda_out_q   <= sda_out_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      byte_done_q <= byte_done_d;
    end
  end

  // Bus conditions override any bit-level transition in the same cycle.
  always_comb begin
    state_d = state_q;
    if (start_cond) begin
      state_d = ADDR;
    end else if (stop_cond) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR:     if (sclk_fall && byte_done_q) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (sclk_fall) state_d = rw_q ? TX : RX;
        RX:       if (sclk_fall && byte_done_q) state_d = RX_ACK;
        RX_ACK:   if (sclk_fall) state_d = RX;
        TX:       if (sclk_fall && byte_done_q) state_d = TX_ACK;
        TX_ACK: begin
          if (sclk_rise && sda_s) state_d = WAIT_STOP;
          else if (sclk_fall)     state_d = TX;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    sda_out_d   = sda_out_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    busy_d      = busy_q;
    rw_d        = rw_q;
    byte_done_d = byte_done_q;
    if (start_cond || stop_cond) begin
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_out_d   = 1'b1;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR, RX: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              if (state_q == RX) begin
                rx_data_d  = {shift_q[6:0], sda_s};
                rx_valid_d = 1'b1;
              end
            end
          end else if (sclk_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == RX) begin
              sda_out_d = 1'b0;
            end else begin
              rw_d = shift_q[0];
              if (addr_match) begin
                sda_out_d = 1'b0;
                busy_d    = 1'b1;
              end
            end
          end
        end
        ADDR_ACK, TX_ACK: begin
          // TX_ACK only sees a falling edge after an ACK; a NACK leaves on the rising edge.
          if (state_q == TX_ACK && sclk_rise && sda_s) begin
            busy_d    = 1'b0;
            sda_out_d = 1'b1;
          end else if (sclk_fall) begin
            bit_cnt_d = 3'd0;
            if (state_q == TX_ACK || rw_q) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
              sda_out_d = tx_data[7];
            end else begin
              sda_out_d = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (sclk_fall) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 3'd0;
          end
        end
        TX: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (sclk_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_out_d   = 1'b1;
            end else begin
              sda_out_d = shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end
        end
        default: sda_out_d = 1'b1;
      endcase
    end
  end

  assign sda_out  = sda_out_q;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: acts as bus master with 8-cycle sclk phases and checks
// ACKs, read data, rx/tx pulses, busy and state with immediate assertions.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  int         rxCount = 0;
  int         txCount = 0;
  int         sdaLowCount = 0;
  int         longPulses = 0;
  logic [7:0] lastRx = 8'h00;
  logic       rxPrev = 1'b0;
  logic       txPrev = 1'b0;

  i2c_slave #(.SLAVE_ADDR(7'h2D), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sda_in(sda_in), .sda_out(sda_out),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxCount <= rxCount + 1;
      lastRx  <= rx_data;
    end
    if (tx_load) txCount <= txCount + 1;
    if (!sda_out) sdaLowCount <= sdaLowCount + 1;
    if ((rx_valid && rxPrev) || (tx_load && txPrev)) longPulses <= longPulses + 1;
    rxPrev <= rx_valid;
    txPrev <= tx_load;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One sclk period with sclk low on entry and exit; returns sda_out seen mid-high.
  task automatic applyStimulus(input logic b, output logic slaveBit);
    sda_in = b;
    waitClk(4);
    sclk = 1'b1;
    waitClk(6);
    slaveBit = sda_out;
    waitClk(2);
    sclk = 1'b0;
    waitClk(4);
  endtask

  task automatic busStart();
    sda_in = 1'b1;
    sclk   = 1'b1;
    waitClk(8);
    sda_in = 1'b0;
    waitClk(8);
    sclk = 1'b0;
    waitClk(4);
  endtask

  task automatic busStop();
    sda_in = 1'b0;
    waitClk(4);
    sclk = 1'b1;
    waitClk(8);
    sda_in = 1'b1;
    waitClk(8);
  endtask

  task automatic sendByte(input logic [7:0] data, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) applyStimulus(data[i], dummy);
    applyStimulus(1'b1, ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] data);
    logic b;
    logic dummy;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, b);
      data = {data[6:0], b};
    end
    applyStimulus(masterAck, dummy);
  endtask

  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] rd;
    int         rx0, tx0, low0;

    rst = 1'b1; sclk = 1'b1; sda_in = 1'b1; tx_data = 8'h00;
    waitClk(3);
    checkOutput("reset_sda", sda_out, 1);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_tx_load", tx_load, 0);
    rst = 1'b0;
    waitClk(4);

    $display("[TB] single-byte write");
    rx0 = rxCount;
    busStart();
    checkOutput("wr_state_addr", state, 1);
    sendByte(8'h5A, ack);
    checkOutput("wr_addr_ack", ack, 0);
    checkOutput("wr_busy", busy, 1);
    checkOutput("wr_state_rx", state, 3);
    sendByte(8'hA5, ack);
    checkOutput("wr_data_ack", ack, 0);
    checkOutput("wr_rx_count", rxCount - rx0, 1);
    checkOutput("wr_rx_data", lastRx, 8'hA5);
    busStop();
    checkOutput("wr_busy_end", busy, 0);
    checkOutput("wr_state_end", state, 0);

    $display("[TB] read with master NACK");
    tx_data = 8'h3C;
    tx0 = txCount;
    busStart();
    sendByte(8'h5B, ack);
    checkOutput("rd_addr_ack", ack, 0);
    checkOutput("rd_state_tx", state, 5);
    checkOutput("rd_busy", busy, 1);
    readByte(1'b1, rd);
    checkOutput("rd_data", rd, 8'h3C);
    checkOutput("rd_tx_load_count", txCount - tx0, 1);
    checkOutput("rd_state_wait", state, 7);
    checkOutput("rd_busy_nack", busy, 0);
    checkOutput("rd_sda_released", sda_out, 1);
    busStop();
    checkOutput("rd_state_end", state, 0);

    $display("[TB] address mismatch");
    rx0 = rxCount;
    low0 = sdaLowCount;
    busStart();
    sendByte(8'h5C, ack);
    checkOutput("mm_addr_nack", ack, 1);
    checkOutput("mm_state_wait", state, 7);
    sendByte(8'hFF, ack);
    checkOutput("mm_data_nack", ack, 1);
    checkOutput("mm_state_still_wait", state, 7);
    checkOutput("mm_busy", busy, 0);
    checkOutput("mm_sda_never_low", sdaLowCount - low0, 0);
    checkOutput("mm_no_rx", rxCount - rx0, 0);
    busStop();
    checkOutput("mm_state_end", state, 0);

    $display("[TB] two-byte write");
    rx0 = rxCount;
    busStart();
    sendByte(8'h5A, ack);
    checkOutput("wr2_addr_ack", ack, 0);
    sendByte(8'h01, ack);
    checkOutput("wr2_ack1", ack, 0);
    checkOutput("wr2_rx1", lastRx, 8'h01);
    sendByte(8'h80, ack);
    checkOutput("wr2_ack2", ack, 0);
    checkOutput("wr2_rx2", lastRx, 8'h80);
    checkOutput("wr2_rx_count", rxCount - rx0, 2);
    busStop();

    $display("[TB] partial byte then new write");
    rx0 = rxCount;
    busStart();
    sendByte(8'h5A, ack);
    checkOutput("part_addr_ack", ack, 0);
    applyStimulus(1'b1, dummy);
    applyStimulus(1'b0, dummy);
    applyStimulus(1'b1, dummy);
    applyStimulus(1'b0, dummy);
    busStop();
    checkOutput("part_no_rx", rxCount - rx0, 0);
    checkOutput("part_state_idle", state, 0);
    busStart();
    sendByte(8'h5A, ack);
    checkOutput("part2_addr_ack", ack, 0);
    sendByte(8'h55, ack);
    checkOutput("part2_data_ack", ack, 0);
    checkOutput("part2_rx_data", lastRx, 8'h55);
    checkOutput("part2_rx_count", rxCount - rx0, 1);
    busStop();

    $display("[TB] reset during TX bit");
    tx_data = 8'h3C;
    busStart();
    sendByte(8'h5B, ack);
    checkOutput("rst_addr_ack", ack, 0);
    sda_in = 1'b1;
    waitClk(4);
    sclk = 1'b1;
    waitClk(6);
    checkOutput("rst_tx_bit_low", sda_out, 0);
    rst = 1'b1;
    waitClk(1);
    checkOutput("rst_sda", sda_out, 1);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    waitClk(4);
    sclk = 1'b0;
    waitClk(8);
    busStart();
    sendByte(8'h5A, ack);
    checkOutput("rst_readdr_ack", ack, 0);
    checkOutput("rst_readdr_busy", busy, 1);
    busStop();
    checkOutput("rst_final_state", state, 0);

    checkOutput("pulse_width", longPulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
